// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: arbiter FSM state type and a one-hot decoder wide enough for any
// practical requester count; callers size-cast the result to NREQ bits.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Decoder width; callers truncate with a size cast to their own NREQ.
  localparam int OH_W     = 64;
  localparam int OH_IDX_W = $clog2(OH_W);

  function automatic logic [OH_W-1:0] onehot(input logic [OH_IDX_W-1:0] idx);
    logic [OH_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the shared FIFO write port.
// Latency: n/a (signal bundle only).
// Backpressure: wfull from the FIFO stalls the granted requester.
//
// Ports (per modport):
//   slave  : the arbiter  - sees req/req_data/wfull, drives w_en/wdata/ack/grant/busy
//   master : the environment (requesters + FIFO write-pointer block)
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  wfull;
  logic                  w_en;
  logic [DSIZE-1:0]      wdata;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       grant;
  logic                  busy;

  modport slave (
    input  req, req_data, wfull,
    output w_en, wdata, ack, grant, busy
  );

  modport master (
    output req, req_data, wfull,
    input  w_en, wdata, ack, grant, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority pick: first set req bit after 'last', wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; valid=0 when no request is set.
//
// Ports: req[NREQ] requests, last[IW] previous winner,
//        winner[IW] selected index, valid = any request present.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  logic [IW-1:0] idx;

  // Scan last+1 .. last+NREQ; k=NREQ lands back on 'last' itself, so a sole
  // requester that just finished can still be re-granted.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one async-FIFO write port among NREQ requesters.
// Latency: one arbitration cycle per grant, then up to BURST_MAX writes, one per cycle.
// Backpressure: wfull=1 stalls the owner (no write, count and grant held).
//
// Ports: wclk write clock; wrst synchronous active-high reset;
//        bus (slave modport): req/req_data/wfull in, w_en/wdata/ack/grant/busy out.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int DSIZE     = 8,
  parameter  int BURST_MAX = 4,
  localparam int CW        = $clog2(BURST_MAX + 1),
  localparam int IW        = $clog2(NREQ)
) (
  input  logic               wclk,
  input  logic               wrst,
  fifo_wr_arbiter_if.slave   bus
);

  arb_state_t     state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  last_q,  last_d;
  logic [CW-1:0]  cnt_q,   cnt_d;

  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic             own_req;
  logic             wr;
  logic             last_word;
  logic [NREQ-1:0]  owner_oh;
  logic [DSIZE-1:0] sel_dat;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.req),
    .last   (last_q),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  assign owner_oh  = NREQ'(onehot(OH_IDX_W'(owner_q)));
  assign own_req   = bus.req[owner_q];
  // Internal write qualifier; the reset gating is applied on the outputs only,
  // since a reset edge overrides any state update anyway.
  assign wr        = (state_q == BURST) && own_req && !bus.wfull;
  assign last_word = (cnt_q == CW'(BURST_MAX - 1));

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) sel_dat = bus.req_data[i*DSIZE +: DSIZE];
    end
  end

  // Next-state logic. Release on the BURST_MAX-th word, or when the owner's
  // request is low (which implies no write). A stall under wfull with req
  // still high keeps the burst open.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BURST;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (!own_req || (wr && last_word)) begin
          state_d = IDLE;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if (wr) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write-side outputs are forced low while wrst is held so nothing reaches
  // the FIFO during the reset cycle, even if it lands mid-burst.
  assign bus.busy  = (state_q == BURST);
  assign bus.grant = bus.busy ? owner_oh : '0;
  assign bus.w_en  = wr && !wrst;
  assign bus.ack   = bus.w_en ? owner_oh : '0;
  assign bus.wdata = (bus.busy && !wrst) ? sel_dat : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, burst cap, rotation,
// backpressure, early release, wrap-around.
module tb_fifo_wr_arbiter;

  logic wclk;
  logic wrst;
  int   n_tests;
  int   n_fail;

  fifo_wr_arbiter_if #(.NREQ(4), .DSIZE(8)) bus ();

  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .BURST_MAX(4)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  // Arbitration cycle: nothing granted, nothing written.
  task automatic idle_cyc(input string tag);
    #1;
    chk({tag, " idle grant"}, 32'(bus.grant), 32'h0);
    chk({tag, " idle busy"},  32'(bus.busy),  32'h0);
    chk({tag, " idle w_en"},  32'(bus.w_en),  32'h0);
    chk({tag, " idle ack"},   32'(bus.ack),   32'h0);
    cyc();
  endtask

  // One word written by requester i.
  task automatic wr_cyc(input string tag, input int i);
    logic [3:0] oh;
    logic [7:0] d;
    oh = 4'(1 << i);
    d  = 8'(8'hA0 + i);
    #1;
    chk({tag, " wr grant"}, 32'(bus.grant), 32'(oh));
    chk({tag, " wr busy"},  32'(bus.busy),  32'h1);
    chk({tag, " wr w_en"},  32'(bus.w_en),  32'h1);
    chk({tag, " wr ack"},   32'(bus.ack),   32'(oh));
    if (bus.w_en) chk({tag, " wr wdata"}, 32'(bus.wdata), 32'(d));
    cyc();
  endtask

  // Owner i granted but not writing (stall or release cycle).
  task automatic hold_cyc(input string tag, input int i);
    #1;
    chk({tag, " hold grant"}, 32'(bus.grant), 32'(4'(1 << i)));
    chk({tag, " hold busy"},  32'(bus.busy),  32'h1);
    chk({tag, " hold w_en"},  32'(bus.w_en),  32'h0);
    chk({tag, " hold ack"},   32'(bus.ack),   32'h0);
    cyc();
  endtask

  task automatic do_reset(input string tag);
    wrst = 1'b1;
    #1;
    chk({tag, " rst w_en"},  32'(bus.w_en),  32'h0);
    chk({tag, " rst ack"},   32'(bus.ack),   32'h0);
    chk({tag, " rst wdata"}, 32'(bus.wdata), 32'h0);
    cyc();
    wrst = 1'b0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    wrst         = 1'b1;
    bus.req      = 4'b0000;
    bus.wfull    = 1'b0;
    bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset state
    cyc();
    chk("reset grant", 32'(bus.grant), 32'h0);
    chk("reset busy",  32'(bus.busy),  32'h0);
    chk("reset w_en",  32'(bus.w_en),  32'h0);
    chk("reset ack",   32'(bus.ack),   32'h0);
    chk("reset wdata", 32'(bus.wdata), 32'h0);
    wrst = 1'b0;

    // Round-robin rotation from reset: A0x4, A1x4, A2x4, A3x4, then A0 again
    bus.req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      idle_cyc("rot");
      for (int w = 0; w < 4; w++) wr_cyc("rot", g);
    end
    idle_cyc("rot wrap");
    wr_cyc("rot again", 0);

    // Reset mid-burst: requester 0 alone, second word, then reset
    bus.req = 4'b0001;
    wr_cyc("midrst", 0);
    wrst = 1'b1;
    #1;
    chk("midrst w_en gated",  32'(bus.w_en),  32'h0);
    chk("midrst ack gated",   32'(bus.ack),   32'h0);
    chk("midrst wdata gated", 32'(bus.wdata), 32'h0);
    cyc();
    wrst = 1'b0;
    idle_cyc("midrst after");
    for (int w = 0; w < 4; w++) wr_cyc("midrst reburst", 0);
    bus.req = 4'b0000;
    idle_cyc("midrst done");

    // Single requester burst cap: 4 writes, 1 idle, 4 writes
    bus.req = 4'b0100;
    idle_cyc("cap");
    for (int w = 0; w < 4; w++) wr_cyc("cap b1", 2);
    idle_cyc("cap gap");
    for (int w = 0; w < 4; w++) wr_cyc("cap b2", 2);
    bus.req = 4'b0000;
    idle_cyc("cap done");

    // Backpressure: owner 1, wfull for 3 cycles after 2 words
    bus.req = 4'b0010;
    idle_cyc("bp");
    wr_cyc("bp", 1);
    wr_cyc("bp", 1);
    bus.wfull = 1'b1;
    for (int s = 0; s < 3; s++) hold_cyc("bp stall", 1);
    bus.wfull = 1'b0;
    wr_cyc("bp resume", 1);
    wr_cyc("bp resume", 1);
    bus.req = 4'b0000;
    idle_cyc("bp done");

    // Early release: last-winner back to 3, requester 0 drops after 2 words
    do_reset("early");
    bus.req = 4'b1001;
    idle_cyc("early");
    wr_cyc("early r0", 0);
    wr_cyc("early r0", 0);
    bus.req = 4'b1000;
    hold_cyc("early release", 0);
    idle_cyc("early rearb");
    for (int w = 0; w < 4; w++) wr_cyc("early r3", 3);
    bus.req = 4'b0000;
    idle_cyc("early done");

    // Wrap-around: last-winner=3 from the previous burst, req=1001 picks 0;
    // owner then drops right after its final word
    bus.req = 4'b1001;
    idle_cyc("wrap");
    for (int w = 0; w < 4; w++) wr_cyc("wrap r0", 0);
    bus.req = 4'b0000;
    idle_cyc("wrap drop");
    bus.req = 4'b1000;
    idle_cyc("wrap next");
    wr_cyc("wrap r3", 3);
    bus.req = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
